dft_bin_streamer: RTL and testbench

- Captures a full multi-bin complex DFT result frame when the DFT core reports completion.
- Double-buffers the frame so the DFT can keep running while the previous result is drained.
- Streams each captured frame out as a framed valid/ready word sequence: one header word, then re/im words per bin.
- Sits between the DFT_SPI core's X/done outputs and the host readout path, replacing the free-running output register snapshot.

---
 rtl/dft_pkg.sv | 24 ++
 rtl/dft_frame_mux.sv | 38 +++
 rtl/dft_bin_streamer.sv | 163 ++++++++++++++++
 tb/tb_dft_bin_streamer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dft_pkg.sv
// Shared types and helpers for the DFT bin streamer: FSM states, header layout
// and the sign-extension / frame-length helpers used by the streamer and its word mux.
package dft_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HDR,
      ST_DATA
   } state_t;

   // Header marker sits this many bits below the top of the word (1 = MSB).
   localparam int HDR_MARK_FROM_TOP = 1;

   function automatic logic [63:0] sext_word(input logic [63:0] value, input int srcWidth);
      logic signed [63:0] shifted;
      shifted = signed'(value << (64 - srcWidth));
      return shifted >>> (64 - srcWidth);
   endfunction

   function automatic int words_per_frame(input int binNum);
      return 1 + 2 * binNum;
   endfunction

endpackage

// File: rtl/dft_frame_mux.sv
// Combinational word selector: picks one re/im component of the active frame
// by word index and sign-extends it, or formats the frame header word.
module dft_frame_mux
   import dft_pkg::*;
#(
   parameter int DFT_WIDTH  = 12,
   parameter int BIN_NUM    = 4,
   parameter int WORD_WIDTH = 16,
   parameter int FCNT_WIDTH = 8,
   parameter int IDX_W      = $clog2(2 * BIN_NUM)
) (
   input  logic [BIN_NUM*2*DFT_WIDTH-1:0] i_buf,
   input  logic [IDX_W-1:0]               i_idx,
   input  logic                           i_hdr_sel,
   input  logic [FCNT_WIDTH-1:0]          i_tag,
   output logic [WORD_WIDTH-1:0]          o_word
);

   logic [DFT_WIDTH-1:0] w_comp;

   // Component layout is re/im interleaved, so word index k maps straight to slot k.
   always_comb begin
      w_comp = '0;
      for (int k = 0; k < 2 * BIN_NUM; k++) begin
         if (i_idx == IDX_W'(k)) begin
            w_comp = i_buf[k*DFT_WIDTH +: DFT_WIDTH];
         end
      end
      o_word = '0;
      if (i_hdr_sel) begin
         o_word[WORD_WIDTH-HDR_MARK_FROM_TOP] = 1'b1;
         o_word[FCNT_WIDTH-1:0]               = i_tag;
      end else begin
         o_word = WORD_WIDTH'(sext_word(64'(w_comp), DFT_WIDTH));
      end
   end

endmodule

// File: rtl/dft_bin_streamer.sv
// Double-buffered capture of DFT result frames with a framed valid/ready output:
// one header word carrying the frame tag, then re/im words for every bin.
module dft_bin_streamer
   import dft_pkg::*;
#(
   parameter int DFT_WIDTH  = 12,
   parameter int BIN_NUM    = 4,
   parameter int WORD_WIDTH = 16,
   parameter int FCNT_WIDTH = 8
) (
   input  logic                           i_sys_clk,
   input  logic                           i_rst,
   input  logic [BIN_NUM*2*DFT_WIDTH-1:0] i_X,
   input  logic                           i_done,
   input  logic                           i_clear,
   output logic [WORD_WIDTH-1:0]          o_tdata,
   output logic                           o_tvalid,
   input  logic                           i_tready,
   output logic                           o_tlast,
   output logic [FCNT_WIDTH-1:0]          o_frame_cnt,
   output logic                           o_overflow,
   output logic                           o_busy
);

   localparam int FRAME_BITS = BIN_NUM * 2 * DFT_WIDTH;
   localparam int IDX_W      = $clog2(2 * BIN_NUM);
   localparam int LAST_IDX   = words_per_frame(BIN_NUM) - 2;

   if (WORD_WIDTH < DFT_WIDTH || WORD_WIDTH < FCNT_WIDTH + 1) begin : g_bad_width
      $error("dft_bin_streamer: WORD_WIDTH too narrow for DFT_WIDTH or FCNT_WIDTH+1");
   end

   state_t                  r_state;
   logic [FRAME_BITS-1:0]   r_pend;
   logic [FRAME_BITS-1:0]   r_active;
   logic [FCNT_WIDTH-1:0]   r_pend_tag;
   logic                    r_pend_valid;
   logic [IDX_W-1:0]        r_idx;
   logic [FCNT_WIDTH-1:0]   r_frame_cnt;
   logic                    r_overflow;
   logic [WORD_WIDTH-1:0]   r_tdata;
   logic                    r_tvalid;
   logic                    r_tlast;
   logic                    r_busy;

   logic                    w_handshake;
   logic                    w_transfer;
   logic                    w_pend_free;
   logic                    w_capture;
   logic                    w_last_hs;
   logic                    w_pend_valid_nxt;
   logic                    w_active_nxt;
   logic                    w_sel_hdr;
   logic [IDX_W-1:0]        w_sel_idx;
   logic [WORD_WIDTH-1:0]   w_word;

   assign w_handshake      = r_tvalid & i_tready;
   assign w_transfer       = (r_state == ST_IDLE) & r_pend_valid;
   // The pending slot can be refilled in the very cycle it hands its frame over.
   assign w_pend_free      = ~r_pend_valid | w_transfer;
   assign w_capture        = i_done & w_pend_free;
   assign w_last_hs        = (r_state == ST_DATA) & w_handshake & (r_idx == IDX_W'(LAST_IDX));
   assign w_pend_valid_nxt = w_capture | (r_pend_valid & ~w_transfer);
   assign w_active_nxt     = (r_state == ST_IDLE) ? r_pend_valid : ~w_last_hs;

   // The mux looks one word ahead so the output register loads the next word on a handshake.
   assign w_sel_hdr = (r_state == ST_IDLE);
   assign w_sel_idx = (r_state == ST_DATA) ? r_idx + 1'b1 : '0;

   dft_frame_mux #(
      .DFT_WIDTH  (DFT_WIDTH),
      .BIN_NUM    (BIN_NUM),
      .WORD_WIDTH (WORD_WIDTH),
      .FCNT_WIDTH (FCNT_WIDTH),
      .IDX_W      (IDX_W)
   ) u_mux (
      .i_buf     (r_active),
      .i_idx     (w_sel_idx),
      .i_hdr_sel (w_sel_hdr),
      .i_tag     (r_pend_tag),
      .o_word    (w_word)
   );

   always_ff @(posedge i_sys_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state      <= ST_IDLE;
         r_pend       <= '0;
         r_active     <= '0;
         r_pend_tag   <= '0;
         r_pend_valid <= 1'b0;
         r_idx        <= '0;
         r_frame_cnt  <= '0;
         r_overflow   <= 1'b0;
         r_tdata      <= '0;
         r_tvalid     <= 1'b0;
         r_tlast      <= 1'b0;
         r_busy       <= 1'b0;
      end else if (i_clear) begin
         r_state      <= ST_IDLE;
         r_pend_valid <= 1'b0;
         r_idx        <= '0;
         r_frame_cnt  <= '0;
         r_overflow   <= 1'b0;
         r_tdata      <= '0;
         r_tvalid     <= 1'b0;
         r_tlast      <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_pend_valid <= w_pend_valid_nxt;
         r_busy       <= w_active_nxt | w_pend_valid_nxt;
         if (w_capture) begin
            r_pend      <= i_X;
            r_pend_tag  <= r_frame_cnt + 1'b1;
            r_frame_cnt <= r_frame_cnt + 1'b1;
         end else if (i_done) begin
            r_overflow  <= 1'b1;
         end
         case (r_state)
            ST_IDLE: begin
               if (r_pend_valid) begin
                  r_active <= r_pend;
                  r_state  <= ST_HDR;
                  r_tvalid <= 1'b1;
                  r_tlast  <= 1'b0;
                  r_tdata  <= w_word;
               end
            end
            ST_HDR: begin
               if (w_handshake) begin
                  r_state <= ST_DATA;
                  r_idx   <= '0;
                  r_tdata <= w_word;
                  r_tlast <= 1'b0;
               end
            end
            ST_DATA: begin
               if (w_handshake) begin
                  if (r_idx == IDX_W'(LAST_IDX)) begin
                     r_state  <= ST_IDLE;
                     r_idx    <= '0;
                     r_tvalid <= 1'b0;
                     r_tlast  <= 1'b0;
                     r_tdata  <= '0;
                  end else begin
                     r_idx   <= w_sel_idx;
                     r_tdata <= w_word;
                     r_tlast <= (w_sel_idx == IDX_W'(LAST_IDX));
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_tdata     = r_tdata;
   assign o_tvalid    = r_tvalid;
   assign o_tlast     = r_tlast;
   assign o_frame_cnt = r_frame_cnt;
   assign o_overflow  = r_overflow;
   assign o_busy      = r_busy;

endmodule

// File: tb/tb_dft_bin_streamer.sv
// Self-checking bench for dft_bin_streamer: a frame-level reference model is compared
// against the DUT every cycle, plus literal expectations for the directed scenarios.
module tb_dft_bin_streamer;

   localparam int DW    = 12;
   localparam int BINS  = 4;
   localparam int WW    = 16;
   localparam int FW    = 8;
   localparam int WORDS = 1 + 2 * BINS;

   logic              clk = 1'b0;
   logic              rstN = 1'b0;
   logic [95:0]       iX = '0;
   logic              iDone = 1'b0;
   logic              iClear = 1'b0;
   logic              tready = 1'b0;
   logic [WW-1:0]     tdata;
   logic              tvalid;
   logic              tlast;
   logic [FW-1:0]     fcnt;
   logic              ovf;
   logic              busy;

   int checks = 0;
   int failures = 0;

   logic [16:0] capQ[$];

   logic [15:0] mCur[WORDS];
   logic [15:0] mPend[WORDS];
   int          mPos = 0;
   bit          mStream = 0;
   bit          mPendV = 0;
   bit          mOvf = 0;
   logic [7:0]  mCnt = '0;
   bit          mXfer;
   bit          mFree;

   logic [95:0] xFirst;
   logic [95:0] xRand;
   logic [15:0] expWords[WORDS];

   dft_bin_streamer #(
      .DFT_WIDTH  (DW),
      .BIN_NUM    (BINS),
      .WORD_WIDTH (WW),
      .FCNT_WIDTH (FW)
   ) dut (
      .i_sys_clk   (clk),
      .i_rst       (rstN),
      .i_X         (iX),
      .i_done      (iDone),
      .i_clear     (iClear),
      .o_tdata     (tdata),
      .o_tvalid    (tvalid),
      .i_tready    (tready),
      .o_tlast     (tlast),
      .o_frame_cnt (fcnt),
      .o_overflow  (ovf),
      .o_busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, then wait for the next falling edge.
   task automatic applyStimulus(input bit d, input logic [95:0] x, input bit c, input bit r);
      iDone  = d;
      iX     = x;
      iClear = c;
      tready = r;
      @(negedge clk);
   endtask

   task automatic drainUntil(input string name, input int n, input int budget, input int mode);
      int cyc;
      cyc = 0;
      while (capQ.size() < n && cyc < budget) begin
         applyStimulus(1'b0, iX, 1'b0, (mode == 0) ? 1'b1 : (cyc % 2 == 0));
         cyc++;
      end
      checkOutput(name, capQ.size(), n);
   endtask

   function automatic logic [15:0] sext12(input logic [11:0] v);
      return {{4{v[11]}}, v};
   endfunction

   function automatic logic [95:0] packBins(input int re[BINS], input int im[BINS]);
      logic [95:0] x;
      x = '0;
      for (int b = 0; b < BINS; b++) begin
         x[(2*b)*DW +: DW]   = 12'(re[b]);
         x[(2*b+1)*DW +: DW] = 12'(im[b]);
      end
      return x;
   endfunction

   // Reference model: whole frames move pending -> streaming; one word leaves per accepted cycle.
   always @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         mStream = 0;
         mPendV  = 0;
         mOvf    = 0;
         mCnt    = '0;
         mPos    = 0;
      end else if (iClear) begin
         mStream = 0;
         mPendV  = 0;
         mOvf    = 0;
         mCnt    = '0;
         mPos    = 0;
      end else begin
         if (tvalid && tready) capQ.push_back({tlast, tdata});
         mXfer = !mStream && mPendV;
         mFree = !mPendV || mXfer;
         if (mStream) begin
            if (tready) begin
               mPos++;
               if (mPos == WORDS) begin
                  mStream = 0;
                  mPos    = 0;
               end
            end
         end else if (mPendV) begin
            mCur    = mPend;
            mPos    = 0;
            mStream = 1;
            mPendV  = 0;
         end
         if (iDone) begin
            if (mFree) begin
               mCnt++;
               mPend[0] = {8'h80, mCnt};
               for (int b = 0; b < BINS; b++) begin
                  mPend[1+2*b] = sext12(iX[(2*b)*DW +: DW]);
                  mPend[2+2*b] = sext12(iX[(2*b+1)*DW +: DW]);
               end
               mPendV = 1;
            end else begin
               mOvf = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rstN) begin
         checkOutput("cmp_tvalid", 32'(tvalid), 32'(mStream));
         checkOutput("cmp_tlast", 32'(tlast), 32'(mStream && mPos == WORDS - 1));
         if (mStream) checkOutput("cmp_tdata", 32'(tdata), 32'(mCur[mPos]));
         checkOutput("cmp_frame_cnt", 32'(fcnt), 32'(mCnt));
         checkOutput("cmp_overflow", 32'(ovf), 32'(mOvf));
         checkOutput("cmp_busy", 32'(busy), 32'(mStream || mPendV));
      end
   end

   initial begin
      #5ms;
      failures++;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int re[BINS];
      int im[BINS];
      re = '{1, -1, 2047, -2048};
      im = '{0, 5, -5, 100};
      xFirst = packBins(re, im);
      expWords = '{16'h8001, 16'h0001, 16'h0000, 16'hFFFF, 16'h0005,
                   16'h07FF, 16'hFFFB, 16'hF800, 16'h0064};

      repeat (3) @(negedge clk);
      checkOutput("rst_tvalid", 32'(tvalid), 0);
      checkOutput("rst_tdata", 32'(tdata), 0);
      checkOutput("rst_fcnt", 32'(fcnt), 0);
      checkOutput("rst_busy", 32'(busy), 0);
      rstN = 1'b1;
      @(negedge clk);

      $display("[TB] single frame, header latency");
      capQ.delete();
      applyStimulus(1'b1, xFirst, 1'b0, 1'b1);
      checkOutput("lat_no_hdr_yet", 32'(tvalid), 0);
      applyStimulus(1'b0, xFirst, 1'b0, 1'b1);
      checkOutput("lat_hdr_valid", 32'(tvalid), 1);
      checkOutput("lat_hdr_data", 32'(tdata), 32'h8001);
      drainUntil("frame1_len", WORDS, 40, 0);
      for (int i = 0; i < WORDS && i < capQ.size(); i++) begin
         checkOutput($sformatf("frame1_w%0d", i), 32'(capQ[i][15:0]), 32'(expWords[i]));
         checkOutput($sformatf("frame1_last%0d", i), 32'(capQ[i][16]), 32'(i == WORDS - 1));
      end
      repeat (3) applyStimulus(1'b0, xFirst, 1'b0, 1'b1);

      $display("[TB] backpressure toggle");
      capQ.delete();
      applyStimulus(1'b1, xFirst, 1'b0, 1'b0);
      drainUntil("bp_len", WORDS, 60, 1);
      for (int i = 0; i < WORDS && i < capQ.size(); i++) begin
         checkOutput($sformatf("bp_w%0d", i), 32'(capQ[i][15:0]),
                     (i == 0) ? 32'h8002 : 32'(expWords[i]));
      end
      repeat (3) applyStimulus(1'b0, xFirst, 1'b0, 1'b1);

      $display("[TB] overflow while stalled");
      applyStimulus(1'b0, xFirst, 1'b1, 1'b0);
      capQ.delete();
      applyStimulus(1'b1, {$urandom, $urandom, $urandom}, 1'b0, 1'b0);
      applyStimulus(1'b1, {$urandom, $urandom, $urandom}, 1'b0, 1'b0);
      checkOutput("coincide_ovf", 32'(ovf), 0);
      checkOutput("coincide_cnt", 32'(fcnt), 2);
      applyStimulus(1'b0, iX, 1'b0, 1'b0);
      applyStimulus(1'b1, {$urandom, $urandom, $urandom}, 1'b0, 1'b0);
      checkOutput("ovf_set", 32'(ovf), 1);
      checkOutput("ovf_cnt", 32'(fcnt), 2);
      drainUntil("ovf_len", 2 * WORDS, 80, 0);
      if (capQ.size() >= 2 * WORDS) begin
         checkOutput("ovf_hdr1", 32'(capQ[0][15:0]), 32'h8001);
         checkOutput("ovf_hdr2", 32'(capQ[WORDS][15:0]), 32'h8002);
      end
      repeat (3) applyStimulus(1'b0, iX, 1'b0, 1'b1);

      $display("[TB] clear mid-frame");
      applyStimulus(1'b0, xFirst, 1'b1, 1'b1);
      capQ.delete();
      applyStimulus(1'b1, xFirst, 1'b0, 1'b1);
      drainUntil("clr_pre", 4, 40, 0);
      applyStimulus(1'b1, xFirst, 1'b1, 1'b0);
      checkOutput("clr_tvalid", 32'(tvalid), 0);
      checkOutput("clr_cnt", 32'(fcnt), 0);
      checkOutput("clr_busy", 32'(busy), 0);
      applyStimulus(1'b1, xFirst, 1'b0, 1'b1);
      applyStimulus(1'b0, xFirst, 1'b0, 1'b1);
      checkOutput("clr_next_hdr", 32'(tdata), 32'h8001);
      repeat (15) applyStimulus(1'b0, xFirst, 1'b0, 1'b1);

      $display("[TB] async reset mid-frame");
      capQ.delete();
      applyStimulus(1'b1, xFirst, 1'b0, 1'b1);
      drainUntil("ar_pre", 3, 40, 0);
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("ar_tvalid", 32'(tvalid), 0);
      checkOutput("ar_tlast", 32'(tlast), 0);
      checkOutput("ar_tdata", 32'(tdata), 0);
      checkOutput("ar_busy", 32'(busy), 0);
      @(negedge clk);
      rstN = 1'b1;
      applyStimulus(1'b1, xFirst, 1'b0, 1'b1);
      applyStimulus(1'b0, xFirst, 1'b0, 1'b1);
      checkOutput("ar_next_hdr", 32'(tdata), 32'h8001);
      repeat (15) applyStimulus(1'b0, xFirst, 1'b0, 1'b1);

      $display("[TB] randomized traffic");
      applyStimulus(1'b0, xFirst, 1'b1, 1'b0);
      for (int c = 0; c < 800; c++) begin
         xRand = {$urandom, $urandom, $urandom};
         applyStimulus($urandom_range(0, 6) == 0, xRand, $urandom_range(0, 149) == 0,
                       $urandom_range(0, 3) != 0);
      end
      repeat (30) applyStimulus(1'b0, iX, 1'b0, 1'b1);

      $display("[TB] frame counter wrap");
      applyStimulus(1'b0, iX, 1'b1, 1'b1);
      capQ.delete();
      for (int f = 0; f < 256; f++) begin
         applyStimulus(1'b1, {$urandom, $urandom, $urandom}, 1'b0, 1'b1);
         repeat (10) applyStimulus(1'b0, iX, 1'b0, 1'b1);
      end
      repeat (5) applyStimulus(1'b0, iX, 1'b0, 1'b1);
      checkOutput("wrap_len", capQ.size(), 256 * WORDS);
      if (capQ.size() >= 256 * WORDS) begin
         checkOutput("wrap_hdr_ff", 32'(capQ[254*WORDS][15:0]), 32'h80FF);
         checkOutput("wrap_hdr_00", 32'(capQ[255*WORDS][15:0]), 32'h8000);
      end
      checkOutput("wrap_cnt", 32'(fcnt), 0);
      checkOutput("wrap_ovf", 32'(ovf), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
